// File: rtl/sram_pkg.sv
// Shared types and constants for the asynchronous SRAM controller.
// Holds the FSM state encoding, default bus widths and the legal strobe-length range.
package sram_pkg;

  localparam int unsigned AW_DEF   = 20;
  localparam int unsigned DW_DEF   = 8;
  localparam int unsigned WAIT_MIN = 1;
  localparam int unsigned WAIT_MAX = 15;
  localparam int unsigned CNT_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

endpackage

// File: rtl/sram_ctrl.sv
// Single-port asynchronous SRAM controller: SETUP / ACCESS(WAIT_CYCLES) / HOLD sequence.
// Every pin is a flop output; pad tristate is handled outside this block.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned AW          = AW_DEF,
  parameter int unsigned DW          = DW_DEF,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic          i_req_we,
  input  logic [AW-1:0] i_req_addr,
  input  logic [DW-1:0] i_req_wdata,
  output logic          o_rsp_valid,
  output logic [DW-1:0] o_rsp_rdata,
  output logic [AW-1:0] o_sram_addr,
  output logic          o_sram_ce_n,
  output logic          o_sram_oe_n,
  output logic          o_sram_we_n,
  output logic [DW-1:0] o_sram_dq,
  output logic          o_sram_dq_oe,
  input  logic [DW-1:0] i_sram_dq,
  output state_t        o_dbg_state
);

  if (WAIT_CYCLES < WAIT_MIN || WAIT_CYCLES > WAIT_MAX) begin : g_bad_wait
    $error("sram_ctrl: WAIT_CYCLES must be in 1..15");
  end

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             we_q;

  assign o_dbg_state = state_q;

  // Handshake: a request is taken on the rising edge where i_req_valid && o_req_ready;
  // the requester must hold addr/we/wdata stable while valid is high and ready is low.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      o_req_ready  <= 1'b0;
      o_rsp_valid  <= 1'b0;
      o_rsp_rdata  <= '0;
      o_sram_addr  <= '0;
      o_sram_ce_n  <= 1'b1;
      o_sram_oe_n  <= 1'b1;
      o_sram_we_n  <= 1'b1;
      o_sram_dq    <= '0;
      o_sram_dq_oe <= 1'b0;
    end else begin
      o_rsp_valid <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          o_req_ready <= 1'b1;
          if (i_req_valid && o_req_ready) begin
            // Outputs are loaded with SETUP values on the accept edge itself.
            state_q      <= ST_SETUP;
            we_q         <= i_req_we;
            o_req_ready  <= 1'b0;
            o_sram_addr  <= i_req_addr;
            o_sram_ce_n  <= 1'b0;
            o_sram_oe_n  <= i_req_we;
            o_sram_we_n  <= 1'b1;
            o_sram_dq_oe <= i_req_we;
            if (i_req_we) begin
              o_sram_dq <= i_req_wdata;
            end
          end
        end
        ST_SETUP: begin
          state_q     <= ST_ACCESS;
          cnt_q       <= CNT_W'(WAIT_CYCLES - 1);
          o_sram_we_n <= ~we_q;
        end
        ST_ACCESS: begin
          if (cnt_q == '0) begin
            state_q     <= ST_HOLD;
            o_sram_oe_n <= 1'b1;
            o_sram_we_n <= 1'b1;
            if (!we_q) begin
              o_rsp_rdata <= i_sram_dq;
              o_rsp_valid <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_HOLD: begin
          // dq_oe stays up through HOLD on writes to cover data hold time.
          state_q      <= ST_IDLE;
          o_req_ready  <= 1'b1;
          o_sram_ce_n  <= 1'b1;
          o_sram_oe_n  <= 1'b1;
          o_sram_we_n  <= 1'b1;
          o_sram_dq_oe <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
